// File: rtl/hazard_ctl_pkg.sv
// Shared encodings for the pipeline hazard controller: write-back select,
// forwarding select and shadow-stage field widths.
package hazard_ctl_pkg;

    localparam int WBSEL_W = 2;
    localparam int FWD_W   = 2;

    localparam logic [WBSEL_W-1:0] WB_MEM = 2'd0;
    localparam logic [WBSEL_W-1:0] WB_ALU = 2'd1;
    localparam logic [WBSEL_W-1:0] WB_PC4 = 2'd2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'd0;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'd1;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'd2;

    function automatic logic is_load_sel(input logic [WBSEL_W-1:0] wbsel);
        return wbsel == WB_MEM;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding source selection for one EX operand, comparing its register
// against the MEM and WB shadow stages.
module hazard_fwd_sel
    import hazard_ctl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              use_rs,
    input  logic [REG_AW-1:0] rs,
    input  logic              mem_valid,
    input  logic              mem_regwen,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_regwen,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [FWD_W-1:0]  fwd
);

    // A load sitting in MEM has no result yet; the load-use stall keeps
    // dependants out of EX until it reaches WB, so it is simply skipped here.
    always_comb begin
        fwd = FWD_RF;
        if (ex_valid && use_rs && (rs != '0)) begin
            if (mem_valid && mem_regwen && !mem_is_load && (mem_rd == rs)) begin
                fwd = FWD_MEM;
            end else if (wb_valid && wb_regwen && (wb_rd == rs)) begin
                fwd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: shadows EX/MEM/WB destinations, generates
// load-use stalls, redirect flushes, EX forwarding selects and event counters.
module hazard_ctl
    import hazard_ctl_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_regwen,
    input  logic [WBSEL_W-1:0] id_wbsel,
    input  logic               ex_pcsel,
    output logic               stall_if,
    output logic               stall_id,
    output logic               flush_id,
    output logic               flush_ex,
    output logic [FWD_W-1:0]   fwd_a,
    output logic [FWD_W-1:0]   fwd_b,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic              ex_valid, ex_regwen, ex_is_load, ex_use1, ex_use2;
    logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
    logic              mem_valid, mem_regwen, mem_is_load;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_valid, wb_regwen;
    logic [REG_AW-1:0] wb_rd;

    logic              live_ex;
    logic              redirect;
    logic              luse;
    logic              stall;
    logic [FWD_W-1:0]  sel_a, sel_b;

    // Everything is masked while reset is held so a stall or flush in
    // progress disappears immediately rather than one cycle later.
    assign live_ex  = ex_valid & ~rst;
    assign redirect = ex_pcsel & ~rst;
    assign luse     = live_ex & ex_is_load & ex_regwen & (ex_rd != '0) & id_valid &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign stall    = luse & ~redirect;

    assign stall_if = stall;
    assign stall_id = stall;
    assign flush_id = redirect;
    assign flush_ex = redirect | luse;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_valid    (live_ex),
        .use_rs      (ex_use1),
        .rs          (ex_rs1),
        .mem_valid   (mem_valid),
        .mem_regwen  (mem_regwen),
        .mem_is_load (mem_is_load),
        .mem_rd      (mem_rd),
        .wb_valid    (wb_valid),
        .wb_regwen   (wb_regwen),
        .wb_rd       (wb_rd),
        .fwd         (sel_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_valid    (live_ex),
        .use_rs      (ex_use2),
        .rs          (ex_rs2),
        .mem_valid   (mem_valid),
        .mem_regwen  (mem_regwen),
        .mem_is_load (mem_is_load),
        .mem_rd      (mem_rd),
        .wb_valid    (wb_valid),
        .wb_regwen   (wb_regwen),
        .wb_rd       (wb_rd),
        .fwd         (sel_b)
    );

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            wb_valid    <= mem_valid;
            wb_regwen   <= mem_regwen;
            wb_rd       <= mem_rd;
            mem_valid   <= ex_valid;
            mem_regwen  <= ex_regwen;
            mem_is_load <= ex_is_load;
            mem_rd      <= ex_rd;
            // A flushed or empty ID slot enters EX as a bubble; the other
            // fields are don't-care behind a cleared valid.
            ex_valid    <= id_valid & ~flush_ex;
            ex_regwen   <= id_regwen;
            ex_is_load  <= is_load_sel(id_wbsel);
            ex_rd       <= id_rd;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_use1     <= id_use_rs1;
            ex_use2     <= id_use_rs2;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed pipeline scenarios followed by
// random instruction streams, compared against an instruction-history model.
module tb_hazard_ctl;
    import hazard_ctl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_regwen = 1'b0;
    logic [1:0] id_wbsel = WB_ALU;
    logic       ex_pcsel = 1'b0;

    logic        stall_if, stall_id, flush_id, flush_ex;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_stall_if, s_stall_id, s_flush_id, s_flush_ex;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctl #(.CNT_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwen(id_regwen), .id_wbsel(id_wbsel), .ex_pcsel(ex_pcsel),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctl #(.CNT_W(4), .REG_AW(5)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwen(id_regwen), .id_wbsel(id_wbsel), .ex_pcsel(ex_pcsel),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .flush_id(s_flush_id), .flush_ex(s_flush_ex),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // One entry per instruction in flight: [0] is in EX, [1] one older, [2] two older.
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       we;
        bit       ld;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
    } instr_t;

    instr_t hist [3];
    int     n_stall = 0;
    int     n_flush = 0;
    int     cmp_cnt = 0;
    int     fail_cnt = 0;

    bit       obs_stall_if, obs_stall_id, obs_flush_id, obs_flush_ex;
    bit [1:0] obs_fa, obs_fb;

    function automatic bit produces(instr_t older, bit [4:0] r);
        return older.valid && older.we && (older.rd == r);
    endfunction

    // Youngest older instruction writing the register wins; an unfinished
    // load one step ahead cannot supply a value and is looked past.
    function automatic bit [1:0] source_for(bit [4:0] r, bit used);
        if (!hist[0].valid || !used || r == 5'd0) return 2'd0;
        if (produces(hist[1], r) && !hist[1].ld) return 2'd1;
        if (produces(hist[2], r)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic int sat15(int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        assert (got === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                                  input bit u1, input bit u2, input bit [4:0] rd,
                                  input bit we, input bit [1:0] wbsel, input bit pcsel);
        bit       hazard, redirect, e_stall, e_fex;
        bit [1:0] e_fa, e_fb;
        instr_t   nxt;
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_regwen = we; id_wbsel = wbsel; ex_pcsel = pcsel;
        #1;
        hazard   = !rst && hist[0].valid && hist[0].ld && hist[0].we && hist[0].rd != 5'd0 && v &&
                   ((u1 && rs1 == hist[0].rd) || (u2 && rs2 == hist[0].rd));
        redirect = !rst && pcsel;
        e_stall  = hazard && !redirect;
        e_fex    = hazard || redirect;
        e_fa     = rst ? 2'd0 : source_for(hist[0].rs1, hist[0].u1);
        e_fb     = rst ? 2'd0 : source_for(hist[0].rs2, hist[0].u2);
        check_output("stall_if",  32'(stall_if),  32'(e_stall));
        check_output("stall_id",  32'(stall_id),  32'(e_stall));
        check_output("flush_id",  32'(flush_id),  32'(redirect));
        check_output("flush_ex",  32'(flush_ex),  32'(e_fex));
        check_output("fwd_a",     32'(fwd_a),     32'(e_fa));
        check_output("fwd_b",     32'(fwd_b),     32'(e_fb));
        check_output("stall_cnt", stall_cnt,      32'(n_stall));
        check_output("flush_cnt", flush_cnt,      32'(n_flush));
        check_output("stall_cnt_w4", 32'(s_stall_cnt), 32'(sat15(n_stall)));
        check_output("flush_cnt_w4", 32'(s_flush_cnt), 32'(sat15(n_flush)));
        obs_stall_if = stall_if; obs_stall_id = stall_id;
        obs_flush_id = flush_id; obs_flush_ex = flush_ex;
        obs_fa = fwd_a; obs_fb = fwd_b;
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[i].valid = 1'b0;
            n_stall = 0;
            n_flush = 0;
        end else begin
            nxt.valid = v && !e_fex;
            nxt.rd = rd; nxt.we = we; nxt.ld = (wbsel == WB_MEM);
            nxt.rs1 = rs1; nxt.rs2 = rs2; nxt.u1 = u1; nxt.u2 = u2;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = nxt;
            if (e_stall) n_stall++;
            if (redirect) n_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        apply_stimulus(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, WB_ALU, 1'b0);
    endtask

    task automatic load(input bit [4:0] rd, input bit [4:0] rs1);
        apply_stimulus(1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, WB_MEM, 1'b0);
    endtask

    task automatic nop();
        apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WB_ALU, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop();
        nop();
        rst = 1'b0;
    endtask

    initial begin
        bit       rv, ru1, ru2, rwe, rpc;
        bit [4:0] r1, r2, rdd;
        bit [1:0] rwb;

        for (int i = 0; i < 3; i++) hist[i] = '{default: '0};
        do_reset();
        check_output("reset_stall_cnt", stall_cnt, 32'd0);
        check_output("reset_flush_cnt", flush_cnt, 32'd0);

        // ALU result one instruction back comes from MEM
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd6, 5'd5, 5'd1);
        nop();
        check_output("fwd_mem_a", 32'(obs_fa), 32'd1);
        check_output("fwd_mem_b", 32'(obs_fb), 32'd0);
        check_output("fwd_mem_nostall", 32'(obs_stall_if), 32'd0);

        // Two instructions back comes from WB
        alu(5'd5, 5'd1, 5'd2);
        nop();
        alu(5'd7, 5'd1, 5'd5);
        nop();
        check_output("fwd_wb_b", 32'(obs_fb), 32'd2);
        check_output("fwd_wb_a", 32'(obs_fa), 32'd0);

        // Both MEM and WB hold x5: the younger one wins
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd5, 5'd2, 5'd3);
        alu(5'd7, 5'd1, 5'd5);
        nop();
        check_output("fwd_mem_wins", 32'(obs_fb), 32'd1);

        // Load-use: one stall cycle, then both operands from WB
        do_reset();
        load(5'd5, 5'd1);
        alu(5'd6, 5'd5, 5'd5);
        check_output("luse_stall_if", 32'(obs_stall_if), 32'd1);
        check_output("luse_stall_id", 32'(obs_stall_id), 32'd1);
        check_output("luse_flush_ex", 32'(obs_flush_ex), 32'd1);
        alu(5'd6, 5'd5, 5'd5);
        check_output("luse_once", 32'(obs_stall_if), 32'd0);
        nop();
        check_output("luse_fwd_a", 32'(obs_fa), 32'd2);
        check_output("luse_fwd_b", 32'(obs_fb), 32'd2);
        check_output("luse_stall_cnt", stall_cnt, 32'd1);

        // x0 is never a hazard
        alu(5'd0, 5'd1, 5'd2);
        alu(5'd1, 5'd0, 5'd0);
        nop();
        check_output("x0_fwd_a", 32'(obs_fa), 32'd0);
        check_output("x0_fwd_b", 32'(obs_fb), 32'd0);
        load(5'd0, 5'd1);
        alu(5'd2, 5'd0, 5'd0);
        check_output("x0_no_stall", 32'(obs_stall_if), 32'd0);

        // Redirect in the same cycle as a load-use hazard
        do_reset();
        load(5'd5, 5'd1);
        apply_stimulus(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, WB_ALU, 1'b1);
        check_output("redir_flush_id", 32'(obs_flush_id), 32'd1);
        check_output("redir_flush_ex", 32'(obs_flush_ex), 32'd1);
        check_output("redir_stall_if", 32'(obs_stall_if), 32'd0);
        check_output("redir_flush_cnt", flush_cnt, 32'd1);
        check_output("redir_stall_cnt", stall_cnt, 32'd0);
        nop();
        check_output("redir_once", 32'(obs_flush_id), 32'd0);

        // Reset arriving mid-stall
        load(5'd5, 5'd1);
        rst = 1'b1;
        alu(5'd6, 5'd5, 5'd5);
        check_output("rst_stall_if", 32'(obs_stall_if), 32'd0);
        check_output("rst_flush_ex", 32'(obs_flush_ex), 32'd0);
        rst = 1'b0;
        alu(5'd6, 5'd5, 5'd5);
        check_output("post_rst_stall", 32'(obs_stall_if), 32'd0);
        check_output("post_rst_fwd_a", 32'(obs_fa), 32'd0);

        // Twenty stalls: narrow counter pins at 15, wide one keeps going
        do_reset();
        for (int i = 0; i < 20; i++) begin
            load(5'd5, 5'd1);
            alu(5'd6, 5'd5, 5'd5);
            alu(5'd6, 5'd5, 5'd5);
        end
        check_output("sat_stall_w4", 32'(s_stall_cnt), 32'd15);
        check_output("sat_stall_w32", stall_cnt, 32'd20);

        // Random instruction stream; a stalled ID instruction is re-presented
        for (int i = 0; i < 600; i++) begin
            if (!obs_stall_id || rst) begin
                rv  = ($urandom_range(0, 9) != 0);
                r1  = 5'($urandom_range(0, 3));
                r2  = 5'($urandom_range(0, 3));
                rdd = 5'($urandom_range(0, 3));
                ru1 = 1'($urandom_range(0, 1));
                ru2 = 1'($urandom_range(0, 1));
                rwe = ($urandom_range(0, 4) != 0);
                rwb = 2'($urandom_range(0, 2));
            end
            rpc = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 59) == 0);
            apply_stimulus(rv, r1, r2, ru1, ru2, rdd, rwe, rwb, rpc);
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
